rv32i_regfile_mp: RTL and testbench
===================================

RV32I_REGFILE_MP -- requirements
Module: rv32i_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, 32, data width in bits.
REQ-002 SHALL have parameter NREGS, 32, register count; power of two, 2..64; AW = log2(NREGS).
REQ-003 SHALL have parameter NRP, 2, number of read ports, 1..4.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rdy  out  1  high once the init sweep completes.
REQ-007 we0, we1  in  1 each  write enables; port 1 has priority.
REQ-008 wa0, wa1  in  AW each  write addresses.
REQ-009 wd0, wd1  in  XLEN each  write data.
REQ-010 iss_vld  in  1  issue strobe; marks register iss_rd as pending.
REQ-011 iss_rd  in  AW  destination register being issued.
REQ-012 ra  in  NRP*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-013 rd  out  NRP*XLEN  packed read data.
REQ-014 rbusy  out  NRP  per-port flag; high when that port's register has a pending write.

Function
REQ-015 Control SHALL be a two-state FSM: INIT and RUN.
REQ-016 INIT SHALL write zero to register cnt each cycle, with cnt counting from 0 to NREGS-1.
REQ-017 The FSM SHALL move INIT->RUN on the cycle cnt==NREGS-1 is written, so rdy rises NREGS cycles after rst deasserts.
REQ-018 In INIT, we0, we1 and iss_vld SHALL be ignored, and rd and rbusy SHALL read 0.
REQ-019 In RUN, a write on port p SHALL update register wa_p at the clock edge when we_p=1 and wa_p!=0.
REQ-020 If we0 and we1 are both high with wa0==wa1, only wd1 SHALL be stored.
REQ-021 Reads SHALL be combinational, with zero-cycle latency from ra to rd.
REQ-022 Register 0 SHALL always read 0, and its rbusy SHALL always be 0.
REQ-023 The scoreboard SHALL hold one busy bit per register, all cleared in INIT.
- iss_vld=1 sets busy[iss_rd], unless iss_rd==0.
- An accepted write on either port clears busy[wa_p].
REQ-024 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-025 rbusy[k] SHALL equal busy[ra_k] after the same-cycle write/bypass resolution of REQ-033.
REQ-026 Multiple read ports addressing the same register SHALL each return identical data.

Reset
REQ-027 When rst=1, the next state SHALL be INIT with cnt=0, rdy=0 and all busy bits cleared.
REQ-028 rst asserted mid-INIT SHALL restart the sweep from cnt=0.
REQ-029 rst asserted in RUN SHALL re-zero every register through a full sweep.
REQ-030 While rst is high, rd and rbusy SHALL be 0.

Configuration
REQ-031 Macro RV32I_REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-032 Without the macro, rd SHALL return the pre-edge array value, so a same-cycle write is visible next cycle.
REQ-033 With the macro, a read port whose ra matches an accepted same-cycle write SHALL return that wd.
- Port-1 data wins when both writes match.
- The matching rbusy SHALL read 0 in that cycle.
- No forwarding SHALL occur for address 0 or during INIT.

Verification
REQ-034 Reset sequence: rst=1 for 2 cycles, then 0 -> rdy=0 for exactly 32 cycles, then 1; every ra reads 0x00000000.
REQ-035 Dual write collision: RUN, we0=we1=1, wa0=wa1=5, wd0=0x11111111, wd1=0x22222222 -> next cycle ra0=5 returns 0x22222222.
REQ-036 Register 0 write: we0=1, wa0=0, wd0=0xDEADBEEF -> ra0=0 returns 0x00000000 and rbusy[0]=0.
REQ-037 Scoreboard race: iss_vld=1, iss_rd=7; two cycles later we0=1, wa0=7 alongside iss_vld=1, iss_rd=7 -> busy[7] remains 1.
- A later we1=1, wa1=7 alone -> rbusy for ra=7 drops to 0.
REQ-038 Bypass check: we0=1, wa0=3, wd0=0xCAFEF00D with ra0=3 in the same cycle.
- With RV32I_REGFILE_BYPASS_EN: rd0=0xCAFEF00D that cycle.
- Without it: the old value that cycle, and 0xCAFEF00D the next cycle.
REQ-039 Reset mid-sweep: rst pulsed at cnt=10 -> rdy rises 32 cycles after rst deasserts; a we0 issued during INIT leaves its register at 0.

Source files
------------

// File: rtl/rv32i_regfile_mp.sv
// rv32i_regfile_mp: multi-write/multi-read register file with zeroing init sweep and busy scoreboard.
// Define RV32I_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module rv32i_regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NRP = 2,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rdy,
    input  logic              we0,
    input  logic              we1,
    input  logic [AW-1:0]     wa0,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd0,
    input  logic [XLEN-1:0]   wd1,
    input  logic              iss_vld,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP*XLEN-1:0] rd,
    output logic [NRP-1:0]    rbusy
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic run, acc0, acc1, set;
    always_comb begin
        run = state_q == RUN && !rst;
        acc0 = run && we0 && wa0 != '0;
        acc1 = run && we1 && wa1 != '0;
        set = run && iss_vld && iss_rd != '0;
    end
    always_comb begin
        state_d = rst ? INIT : (state_q == INIT && cnt_q == AW'(NREGS - 1)) ? RUN : state_q;
        cnt_d = rst ? '0 : state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    end
    // Port 1 is applied last so it wins an address collision.
    always_comb begin
        mem_d = mem_q;
        if (state_q == INIT) mem_d[cnt_q] = '0;
        if (acc0) mem_d[wa0] = wd0;
        if (acc1) mem_d[wa1] = wd1;
    end
    // Issue is applied after the write clears so a same-register set survives.
    always_comb begin
        busy_d = run ? busy_q : '0;
        if (acc0) busy_d[wa0] = 1'b0;
        if (acc1) busy_d[wa1] = 1'b0;
        if (set) busy_d[iss_rd] = 1'b1;
    end
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        mem_q <= mem_d;
        busy_q <= busy_d;
    end
    assign rdy = state_q == RUN;
    for (genvar k = 0; k < NRP; k++) begin : g_rp
        logic [AW-1:0] a;
        logic hit0, hit1;
        assign a = ra[k*AW +: AW];
`ifdef RV32I_REGFILE_BYPASS_EN
        assign hit1 = acc1 && wa1 == a;
        assign hit0 = acc0 && wa0 == a;
`else
        assign hit1 = 1'b0;
        assign hit0 = 1'b0;
`endif
        assign rd[k*XLEN +: XLEN] = (!run || a == '0) ? '0 : hit1 ? wd1 : hit0 ? wd0 : mem_q[a];
        assign rbusy[k] = run && a != '0 && !hit0 && !hit1 && busy_q[a];
    end
endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// tb_rv32i_regfile_mp: scoreboard-driven bench for rv32i_regfile_mp (default parameters).
module tb_rv32i_regfile_mp;
`ifdef RV32I_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, rdy;
    logic we0 = 1'b0, we1 = 1'b0, iss_vld = 1'b0;
    logic [4:0] wa0 = '0, wa1 = '0, iss_rd = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [9:0] ra = '0;
    logic [63:0] rd;
    logic [1:0] rbusy;
    int checks = 0, passed = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic [31:0] mdl [32];

    rv32i_regfile_mp dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_vld(iss_vld), .iss_rd(iss_rd), .ra(ra), .rd(rd), .rbusy(rbusy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        iss_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ra = {5'd3, 5'd1};
        step();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL rst_rd got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rbusy !== e[1:0]) $display("FAIL rst_rbusy got=%b exp=%b", rbusy, e[1:0]);else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'h0);
            checks++; e = exp_q.pop_front(); if (rdy !== e[0]) $display("FAIL rst_rdy_low cyc=%0d got=%b exp=%b", i, rdy, e[0]); else passed++;
            step();
        end
        exp_q.push_back(32'h1);
        checks++; e = exp_q.pop_front(); if (rdy !== e[0]) $display("FAIL rst_rdy_high got=%b exp=%b", rdy, e[0]); else passed++;
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL rst_zero0 a=%0d got=%h exp=%h", a, rd[31:0], e); else passed++;
            checks++; e = exp_q.pop_front(); if (rd[63:32] !== e) $display("FAIL rst_zero1 a=%0d got=%h exp=%h", a, rd[63:32], e); else passed++;
            mdl[a] = 32'h0;
        end
    endtask

    task automatic test_collision();
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd5; wa1 = 5'd5;
        wd0 = 32'h11111111; wd1 = 32'h22222222;
        ra = {5'd5, 5'd5};
        mdl[5] = 32'h22222222;
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h22222222);
        step();
        idle();
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL collision_rd0 got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rd[63:32] !== e) $display("FAIL collision_rd1 got=%h exp=%h", rd[63:32], e); else passed++;
    endtask

    task automatic test_reg0();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF;
        iss_vld = 1'b1; iss_rd = 5'd0;
        ra = {5'd5, 5'd0};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL reg0_same got=%h exp=%h", rd[31:0], e); else passed++;
        step();
        idle();
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL reg0_next got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rbusy[0] !== e[0]) $display("FAIL reg0_busy got=%b exp=%b", rbusy[0], e[0]); else passed++;
    endtask

    task automatic test_scoreboard();
        iss_vld = 1'b1; iss_rd = 5'd7;
        ra = {5'd7, 5'd7};
        step();
        idle();
        exp_q.push_back(32'h1);
        #1;
        checks++; e = exp_q.pop_front(); if (rbusy[0] !== e[0]) $display("FAIL sb_set got=%b exp=%b", rbusy[0], e[0]); else passed++;
        step();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h07070707;
        iss_vld = 1'b1; iss_rd = 5'd7;
        mdl[7] = 32'h07070707;
        step();
        idle();
        exp_q.push_back(32'h1);
        exp_q.push_back(mdl[7]);
        #1;
        checks++; e = exp_q.pop_front(); if (rbusy[0] !== e[0]) $display("FAIL sb_race got=%b exp=%b", rbusy[0], e[0]); else passed++;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL sb_race_rd got=%h exp=%h", rd[31:0], e); else passed++;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h70707070;
        exp_q.push_back(BYP ? 32'h0 : 32'h1);
        #1;
        checks++; e = exp_q.pop_front(); if (rbusy[1] !== e[0]) $display("FAIL sb_clr_same got=%b exp=%b", rbusy[1], e[0]); else passed++;
        mdl[7] = 32'h70707070;
        step();
        idle();
        exp_q.push_back(32'h0);
        exp_q.push_back(mdl[7]);
        #1;
        checks++; e = exp_q.pop_front(); if (rbusy[1] !== e[0]) $display("FAIL sb_clr got=%b exp=%b", rbusy[1], e[0]); else passed++;
        checks++; e = exp_q.pop_front(); if (rd[63:32] !== e) $display("FAIL sb_clr_rd got=%h exp=%h", rd[63:32], e); else passed++;
    endtask

    task automatic test_bypass();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0BADF00D;
        iss_vld = 1'b1; iss_rd = 5'd3;
        mdl[3] = 32'h0BADF00D;
        step();
        idle();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFEF00D;
        ra = {5'd1, 5'd3};
        exp_q.push_back(BYP ? 32'hCAFEF00D : mdl[3]);
        exp_q.push_back(BYP ? 32'h0 : 32'h1);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL byp_same got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rbusy[0] !== e[0]) $display("FAIL byp_busy_same got=%b exp=%b", rbusy[0], e[0]); else passed++;
        mdl[3] = 32'hCAFEF00D;
        step();
        idle();
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL byp_next got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rbusy[0] !== e[0]) $display("FAIL byp_busy_next got=%b exp=%b", rbusy[0], e[0]); else passed++;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA0001;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hBBBB0002;
        exp_q.push_back(BYP ? 32'hBBBB0002 : mdl[3]);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL byp_prio got=%h exp=%h", rd[31:0], e); else passed++;
        mdl[3] = 32'hBBBB0002;
        step();
        idle();
        exp_q.push_back(mdl[3]);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL byp_prio_next got=%h exp=%h", rd[31:0], e); else passed++;
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int n = 0; n < 60; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = 5'($urandom); wa1 = 5'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            ra = 10'($urandom);
            for (int k = 0; k < 2; k++) begin
                a = ra[k*5 +: 5];
                exp_q.push_back(a == 5'd0 ? 32'h0 :
                                (BYP && we1 && wa1 == a) ? wd1 :
                                (BYP && we0 && wa0 == a) ? wd0 : mdl[a]);
            end
            #1;
            checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL rand_rd0 n=%0d ra=%h got=%h exp=%h", n, ra, rd[31:0], e); else passed++;
            checks++; e = exp_q.pop_front(); if (rd[63:32] !== e) $display("FAIL rand_rd1 n=%0d ra=%h got=%h exp=%h", n, ra, rd[63:32], e); else passed++;
            if (we0 && wa0 != 5'd0) mdl[wa0] = wd0;
            if (we1 && wa1 != 5'd0) mdl[wa1] = wd1;
            step();
        end
        idle();
    endtask

    task automatic test_mid_reset();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99999999;
        iss_vld = 1'b1; iss_rd = 5'd6;
        step();
        idle();
        rst = 1'b1;
        ra = {5'd6, 5'd9};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL mrst_rd got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rbusy[1] !== e[0]) $display("FAIL mrst_busy got=%b exp=%b", rbusy[1], e[0]); else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(32'h0);
            checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL init_rd cyc=%0d got=%h exp=%h", i, rd[31:0], e); else passed++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 25) begin
                we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hFFFFFFFF;
                iss_vld = 1'b1; iss_rd = 5'd6;
            end else idle();
            exp_q.push_back(32'h0);
            checks++; e = exp_q.pop_front(); if (rdy !== e[0]) $display("FAIL mrst_rdy_low cyc=%0d got=%b exp=%b", i, rdy, e[0]); else passed++;
            step();
        end
        idle();
        exp_q.push_back(32'h1);
        checks++; e = exp_q.pop_front(); if (rdy !== e[0]) $display("FAIL mrst_rdy_high got=%b exp=%b", rdy, e[0]); else passed++;
        for (int a = 0; a < 32; a++) mdl[a] = 32'h0;
        ra = {5'd6, 5'd4};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL init_we_ignored got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rbusy[1] !== e[0]) $display("FAIL init_iss_ignored got=%b exp=%b", rbusy[1], e[0]); else passed++;
        ra = {5'd3, 5'd9};
        exp_q.push_back(mdl[9]);
        exp_q.push_back(mdl[3]);
        #1;
        checks++; e = exp_q.pop_front(); if (rd[31:0] !== e) $display("FAIL rezero9 got=%h exp=%h", rd[31:0], e); else passed++;
        checks++; e = exp_q.pop_front(); if (rd[63:32] !== e) $display("FAIL rezero3 got=%h exp=%h", rd[63:32], e); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_collision();
        test_reg0();
        test_scoreboard();
        test_bypass();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
